// File: rtl/exec_unit_hs.sv
// rtl/exec_unit_hs.sv - RV32I/RV64I execute stage with valid/ready decode, memory and writeback handshakes
module exec_unit_hs #(
    parameter int XLEN           = 32,
    parameter bit LANE_MSB_FIRST = 1'b1,
    parameter int ILEN_BYTES     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       in_op,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [1:0]        in_fwd1,
    input  logic [1:0]        in_fwd2,
    input  logic [XLEN-1:0]   fwd_ext,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic              out_wen,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [1:0]        out_exc
);
    localparam int NB   = XLEN / 8;
    localparam int OW   = $clog2(NB);
    localparam int LW   = OW + 2;
    localparam int SHW  = (XLEN == 64) ? 6 : 5;
    localparam bit IS64 = (XLEN == 64);

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;

    typedef enum logic [1:0] {IDLE, MREQ, MRSP, DONE} state_t;
    state_t state_q, state_d;

    logic [XLEN-1:0] out_data_q, redirect_pc_q, mem_addr_q, mem_wdata_q;
    logic            out_wen_q, redirect_valid_q, mem_we_q, ld_unsigned_q;
    logic [1:0]      out_exc_q, ld_size_q;
    logic [NB-1:0]   mem_be_q;
    logic [LW-1:0]   ld_lane_q;

    logic       accept;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7b5;
    assign opc  = in_op[6:0];
    assign f3   = in_op[9:7];
    assign f7b5 = in_op[10];

    logic [XLEN-1:0] opa, opb, op2;
    always_comb begin
        case (in_fwd1)
            2'd1:    opa = out_data_q;
            2'd2:    opa = fwd_ext;
            default: opa = in_rs1;
        endcase
        case (in_fwd2)
            2'd1:    opb = out_data_q;
            2'd2:    opb = fwd_ext;
            default: opb = in_rs2;
        endcase
        op2 = (opc == OPC_OP || opc == OPC_OP32 || opc == OPC_BRANCH) ? opb : in_imm;
    end

    // funct7[5] means SUB only on register forms, SRA on any shift-right form
    logic alt;
    assign alt = f7b5 && (opc == OPC_OP || opc == OPC_OP32 || f3 == 3'b101);

    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;
    assign shamt = op2[SHW-1:0];
    always_comb begin
        case (f3)
            3'b000:  alu_res = alt ? opa - op2 : opa + op2;
            3'b001:  alu_res = opa << shamt;
            3'b010:  alu_res = XLEN'($signed(opa) < $signed(op2));
            3'b011:  alu_res = XLEN'(opa < op2);
            3'b100:  alu_res = opa ^ op2;
            3'b101:  alu_res = alt ? XLEN'($signed(opa) >>> shamt) : opa >> shamt;
            3'b110:  alu_res = opa | op2;
            default: alu_res = opa & op2;
        endcase
    end

    logic [31:0]     w_res;
    logic [XLEN-1:0] w_ext;
    always_comb begin
        case (f3)
            3'b001:  w_res = opa[31:0] << op2[4:0];
            3'b101:  w_res = alt ? 32'($signed(opa[31:0]) >>> op2[4:0]) : opa[31:0] >> op2[4:0];
            default: w_res = alt ? opa[31:0] - op2[31:0] : opa[31:0] + op2[31:0];
        endcase
    end
    assign w_ext = XLEN'($signed(w_res));

    logic taken;
    always_comb begin
        case (f3)
            3'b000:  taken = (opa == opb);
            3'b001:  taken = (opa != opb);
            3'b100:  taken = ($signed(opa) < $signed(opb));
            3'b101:  taken = ($signed(opa) >= $signed(opb));
            3'b110:  taken = (opa < opb);
            3'b111:  taken = (opa >= opb);
            default: taken = 1'b0;
        endcase
    end

    logic [XLEN-1:0] eff_addr;
    logic [1:0]      sz;
    logic [OW-1:0]   off;
    logic            misal;
    logic [LW-1:0]   nbytes, lane;
    assign eff_addr = opa + in_imm;
    assign sz       = f3[1:0];
    assign off      = eff_addr[OW-1:0];
    assign nbytes   = LW'(1) << sz;
    assign lane     = LANE_MSB_FIRST ? LW'(NB) - LW'(off) - nbytes : LW'(off);

    logic [NB-1:0]   be_base, st_be;
    logic [XLEN-1:0] st_data;
    always_comb begin
        case (sz)
            2'd0: begin misal = 1'b0;            be_base = NB'(1);  st_data = {NB{opb[7:0]}};        end
            2'd1: begin misal = eff_addr[0];     be_base = NB'(3);  st_data = {(NB/2){opb[15:0]}};   end
            2'd2: begin misal = |eff_addr[1:0];  be_base = NB'(15); st_data = {(NB/4){opb[31:0]}};   end
            default: begin misal = |eff_addr[2:0]; be_base = '1;    st_data = opb;                   end
        endcase
    end
    assign st_be = be_base << lane;

    logic [XLEN-1:0] res_data, res_pc;
    logic            res_wen, res_redir, redir_req, go_mem, illegal, is_mem;
    logic [1:0]      res_exc;
    always_comb begin
        res_data  = '0;
        res_pc    = '0;
        res_wen   = 1'b0;
        res_redir = 1'b0;
        res_exc   = 2'd0;
        redir_req = 1'b0;
        go_mem    = 1'b0;
        illegal   = 1'b0;
        is_mem    = 1'b0;
        case (opc)
            OPC_OP, OPC_OPIMM: begin
                res_data = alu_res;
                res_wen  = 1'b1;
                illegal  = (opc == OPC_OP) && f7b5 && (f3 != 3'b000) && (f3 != 3'b101);
            end
            OPC_OP32, OPC_OPIMM32: begin
                res_data = w_ext;
                res_wen  = 1'b1;
                illegal  = !IS64 || !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
            end
            OPC_LUI:   begin res_data = in_imm;         res_wen = 1'b1; end
            OPC_AUIPC: begin res_data = in_pc + in_imm; res_wen = 1'b1; end
            OPC_JAL: begin
                res_data  = in_pc + XLEN'(ILEN_BYTES);
                res_wen   = 1'b1;
                redir_req = 1'b1;
                res_pc    = in_pc + in_imm;
            end
            OPC_JALR: begin
                res_data  = in_pc + XLEN'(ILEN_BYTES);
                res_wen   = 1'b1;
                redir_req = 1'b1;
                res_pc    = {eff_addr[XLEN-1:1], 1'b0};
                illegal   = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                redir_req = taken;
                res_pc    = in_pc + in_imm;
                illegal   = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                is_mem  = 1'b1;
                go_mem  = 1'b1;
                res_wen = 1'b1;
                illegal = (f3 == 3'b111) || (!IS64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            OPC_STORE: begin
                is_mem  = 1'b1;
                go_mem  = 1'b1;
                illegal = f3[2] || (!IS64 && f3 == 3'b011);
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            res_exc  = 2'd1;
            res_wen  = 1'b0;
            go_mem   = 1'b0;
            res_data = '0;
        end else if (is_mem && misal) begin
            res_exc = 2'd2;
            res_wen = 1'b0;
            go_mem  = 1'b0;
        end else if (redir_req && res_pc[1]) begin
            res_exc = 2'd3;
            res_wen = 1'b0;
        end else begin
            res_redir = redir_req;
        end
    end

    assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = go_mem ? MREQ : DONE;
            MREQ: if (mem_req_ready) state_d = MRSP;
            MRSP: if (mem_resp_valid) state_d = DONE;
            DONE: begin
                if (accept)         state_d = go_mem ? MREQ : DONE;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [XLEN-1:0] ld_shift, ld_val;
    assign ld_shift = mem_rdata >> {ld_lane_q, 3'b000};
    always_comb begin
        case (ld_size_q)
            2'd0:    ld_val = ld_unsigned_q ? XLEN'(ld_shift[7:0])  : XLEN'($signed(ld_shift[7:0]));
            2'd1:    ld_val = ld_unsigned_q ? XLEN'(ld_shift[15:0]) : XLEN'($signed(ld_shift[15:0]));
            2'd2:    ld_val = ld_unsigned_q ? XLEN'(ld_shift[31:0]) : XLEN'($signed(ld_shift[31:0]));
            default: ld_val = ld_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q       <= '0;
            out_wen_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            out_exc_q        <= 2'd0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            mem_be_q         <= '0;
            ld_size_q        <= 2'd0;
            ld_unsigned_q    <= 1'b0;
            ld_lane_q        <= '0;
        end else if (accept) begin
            out_data_q       <= res_data;
            out_wen_q        <= res_wen;
            redirect_valid_q <= res_redir;
            redirect_pc_q    <= res_pc;
            out_exc_q        <= res_exc;
            mem_we_q         <= (opc == OPC_STORE);
            mem_addr_q       <= {eff_addr[XLEN-1:OW], OW'(0)};
            mem_wdata_q      <= st_data;
            mem_be_q         <= st_be;
            ld_size_q        <= sz;
            ld_unsigned_q    <= f3[2];
            ld_lane_q        <= lane;
        end else if (state_q == MRSP && mem_resp_valid && !mem_we_q) begin
            out_data_q <= ld_val;
        end
    end

    assign mem_req_valid  = (state_q == MREQ);
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_be         = mem_be_q;
    assign out_valid      = (state_q == DONE);
    assign out_data       = out_data_q;
    assign out_wen        = out_wen_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign out_exc        = out_exc_q;
endmodule

// File: tb/tb_exec_unit_hs.sv
// tb/tb_exec_unit_hs.sv - scoreboard bench for exec_unit_hs, both byte-lane orders side by side
module tb_exec_unit_hs;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, mem_req_ready, mem_resp_valid, out_ready;
    logic [10:0] in_op;
    logic [31:0] in_rs1, in_rs2, in_imm, in_pc, fwd_ext, mem_rdata;
    logic [1:0]  in_fwd1, in_fwd2;

    logic        m_in_ready, m_req_valid, m_we, m_out_valid, m_wen, m_rv;
    logic [31:0] m_addr, m_wdata, m_data, m_rpc;
    logic [3:0]  m_be;
    logic [1:0]  m_exc;
    logic        l_in_ready, l_req_valid, l_we, l_out_valid, l_wen, l_rv;
    logic [31:0] l_addr, l_wdata, l_data, l_rpc;
    logic [3:0]  l_be;
    logic [1:0]  l_exc;

    exec_unit_hs #(.XLEN(32), .LANE_MSB_FIRST(1'b1), .ILEN_BYTES(4)) dut_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
        .in_fwd1(in_fwd1), .in_fwd2(in_fwd2), .fwd_ext(fwd_ext),
        .mem_req_valid(m_req_valid), .mem_req_ready(mem_req_ready), .mem_we(m_we),
        .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_be(m_be),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_data), .out_wen(m_wen),
        .redirect_valid(m_rv), .redirect_pc(m_rpc), .out_exc(m_exc)
    );

    exec_unit_hs #(.XLEN(32), .LANE_MSB_FIRST(1'b0), .ILEN_BYTES(4)) dut_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
        .in_fwd1(in_fwd1), .in_fwd2(in_fwd2), .fwd_ext(fwd_ext),
        .mem_req_valid(l_req_valid), .mem_req_ready(mem_req_ready), .mem_we(l_we),
        .mem_addr(l_addr), .mem_wdata(l_wdata), .mem_be(l_be),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_data), .out_wen(l_wen),
        .redirect_valid(l_rv), .redirect_pc(l_rpc), .out_exc(l_exc)
    );

    localparam logic [10:0] OP_ADDI = 11'b0_000_0010011;
    localparam logic [10:0] OP_ADD  = 11'b0_000_0110011;
    localparam logic [10:0] OP_SUB  = 11'b1_000_0110011;
    localparam logic [10:0] OP_SRAI = 11'b1_101_0010011;
    localparam logic [10:0] OP_LUI  = 11'b0_000_0110111;
    localparam logic [10:0] OP_JAL  = 11'b0_000_1101111;
    localparam logic [10:0] OP_JALR = 11'b0_000_1100111;
    localparam logic [10:0] OP_BLT  = 11'b0_100_1100011;
    localparam logic [10:0] OP_BLTU = 11'b0_110_1100011;
    localparam logic [10:0] OP_LB   = 11'b0_000_0000011;
    localparam logic [10:0] OP_LW   = 11'b0_010_0000011;
    localparam logic [10:0] OP_SH   = 11'b0_001_0100011;
    localparam logic [10:0] OP_ADDW = 11'b0_000_0111011;

    typedef struct {
        logic [31:0] dm, dl;
        logic        cd, wen, cw, rv;
        logic [31:0] rpc;
        logic [1:0]  exc;
    } exp_t;
    typedef struct {
        logic        we;
        logic [31:0] addr, wd_m, wd_l;
        logic [3:0]  be_m, be_l;
    } mexp_t;
    typedef struct {
        logic [10:0] op;
        logic [31:0] rs1, rs2, imm, pc;
        logic [1:0]  f2;
        logic [31:0] fext;
        exp_t        e;
    } vec_t;

    exp_t  exp_q[$];
    mexp_t mem_q[$];
    vec_t  vt[11];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] dm, dl, input logic cd, wen, cw, rv,
                                input logic [31:0] rpc, input logic [1:0] exc);
        exp_t e;
        e.dm = dm; e.dl = dl; e.cd = cd; e.wen = wen; e.cw = cw; e.rv = rv; e.rpc = rpc; e.exc = exc;
        return e;
    endfunction

    task automatic set_in(input logic [10:0] op, input logic [31:0] rs1, rs2, imm, pc,
                          input logic [1:0] f1, f2);
        in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc;
        in_fwd1 = f1; in_fwd2 = f2;
    endtask

    task automatic issue(input logic [10:0] op, input logic [31:0] rs1, rs2, imm, pc,
                         input logic [1:0] f1, f2);
        int n;
        set_in(op, rs1, rs2, imm, pc, f1, f2);
        in_valid = 1'b1;
        n = 0;
        while (!m_in_ready && n < 20) begin
            tick;
            n++;
        end
        if (!m_in_ready) chk("issue_timeout", {31'd0, m_in_ready}, 32'd1);
        tick;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin : mon_out
        exp_t e;
        if (!reset && (m_out_valid || l_out_valid) && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {31'd0, m_out_valid | l_out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("lsb_out_valid", {31'd0, l_out_valid}, {31'd0, m_out_valid});
                if (e.cd) begin
                    chk("out_data_msb", m_data, e.dm);
                    chk("out_data_lsb", l_data, e.dl);
                end
                if (e.cw) chk("out_wen", {30'd0, m_wen, l_wen}, {30'd0, e.wen, e.wen});
                chk("redirect_valid", {30'd0, m_rv, l_rv}, {30'd0, e.rv, e.rv});
                if (e.rv) chk("redirect_pc", m_rpc, e.rpc);
                chk("out_exc", {28'd0, m_exc, l_exc}, {28'd0, e.exc, e.exc});
            end
        end
    end

    always @(negedge clk) begin : mon_mem
        mexp_t m;
        if (!reset && (m_req_valid || l_req_valid)) begin
            if (mem_q.size() == 0) begin
                chk("unexpected_mem_req", {31'd0, m_req_valid | l_req_valid}, 32'd0);
            end else begin
                m = mem_q[0];
                chk("mem_addr_msb", m_addr, m.addr);
                chk("mem_addr_lsb", l_addr, m.addr);
                chk("mem_we", {30'd0, m_we, l_we}, {30'd0, m.we, m.we});
                if (m.we) begin
                    chk("mem_be_msb", {28'd0, m_be}, {28'd0, m.be_m});
                    chk("mem_be_lsb", {28'd0, l_be}, {28'd0, m.be_l});
                    chk("mem_wdata_msb", m_wdata, m.wd_m);
                    chk("mem_wdata_lsb", l_wdata, m.wd_l);
                end
                if (mem_req_ready) m = mem_q.pop_front();
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        mexp_t mr;
        reset = 1'b1; in_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        out_ready = 1'b1; mem_rdata = '0; fwd_ext = '0;
        set_in(11'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        repeat (3) tick;
        chk("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
        chk("rst_req_valid", {31'd0, m_req_valid}, 32'd0);
        chk("rst_redirect", {31'd0, m_rv}, 32'd0);
        chk("rst_wen", {31'd0, m_wen}, 32'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_rpc", m_rpc, 32'd0);
        chk("rst_exc", {30'd0, m_exc}, 32'd0);
        reset = 1'b0;
        tick;
        chk("idle_in_ready", {31'd0, m_in_ready}, 32'd1);

        // ADDI then dependent ADD on the very next cycle
        exp_q.push_back(mk(32'd2, 32'd2, 1, 1, 1, 0, 0, 2'd0));
        exp_q.push_back(mk(32'd12, 32'd12, 1, 1, 1, 0, 0, 2'd0));
        set_in(OP_ADDI, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd0, 2'd0, 2'd0);
        in_valid = 1'b1;
        tick;
        chk("b2b_first_data", m_data, 32'd2);
        chk("b2b_in_ready", {31'd0, m_in_ready}, 32'd1);
        set_in(OP_ADD, 32'h999, 32'd10, 32'd0, 32'd0, 2'd1, 2'd0);
        tick;
        in_valid = 1'b0;
        chk("b2b_second_valid", {31'd0, m_out_valid}, 32'd1);
        chk("b2b_second_data", m_data, 32'd12);
        tick;

        // LB at 0x1003 with a stalled request, a stray response and a stalled writeback
        out_ready = 1'b0;
        mr.we = 1'b0; mr.addr = 32'h1000; mr.wd_m = '0; mr.wd_l = '0; mr.be_m = 4'b0001; mr.be_l = 4'b1000;
        mem_q.push_back(mr);
        exp_q.push_back(mk(32'hFFFF_FF80, 32'h0000_0011, 1, 1, 1, 0, 0, 2'd0));
        issue(OP_LB, 32'h1000, 32'd0, 32'd3, 32'd0, 2'd0, 2'd0);
        mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick;
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h1122_3380;
        tick;
        mem_resp_valid = 1'b0; mem_rdata = '0;
        chk("lb_valid", {31'd0, m_out_valid}, 32'd1);
        chk("lb_data", m_data, 32'hFFFF_FF80);
        tick;
        chk("lb_held_valid", {31'd0, m_out_valid}, 32'd1);
        chk("lb_held_data", m_data, 32'hFFFF_FF80);
        out_ready = 1'b1;
        tick;

        // SH at 0x2002 completes only after the store ack
        mr.we = 1'b1; mr.addr = 32'h2000; mr.wd_m = 32'h1234_1234; mr.wd_l = 32'h1234_1234;
        mr.be_m = 4'b0011; mr.be_l = 4'b1100;
        mem_q.push_back(mr);
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'd0));
        issue(OP_SH, 32'h2000, 32'hABCD_1234, 32'd2, 32'd0, 2'd0, 2'd0);
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        tick;
        chk("sh_wait_resp", {31'd0, m_out_valid}, 32'd0);
        mem_resp_valid = 1'b1;
        tick;
        mem_resp_valid = 1'b0;
        tick;

        vt[0]  = '{OP_LW,   32'h1000, 0, 32'd2, 0, 2'd0, 0, mk(0, 0, 0, 0, 1, 0, 0, 2'd2)};
        vt[1]  = '{OP_JALR, 32'h102, 0, 32'd0, 32'h80, 2'd0, 0, mk(0, 0, 0, 0, 0, 0, 0, 2'd3)};
        vt[2]  = '{OP_BLT,  32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 2'd0, 0, mk(0, 0, 0, 0, 1, 1, 32'h120, 2'd0)};
        vt[3]  = '{OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 2'd0, 0, mk(0, 0, 0, 0, 1, 0, 0, 2'd0)};
        vt[4]  = '{OP_JAL,  0, 0, 32'h40, 32'h200, 2'd0, 0, mk(32'h204, 32'h204, 1, 1, 1, 1, 32'h240, 2'd0)};
        vt[5]  = '{OP_SUB,  32'd3, 32'd5, 0, 0, 2'd0, 0, mk(32'hFFFF_FFFE, 32'hFFFF_FFFE, 1, 1, 1, 0, 0, 2'd0)};
        vt[6]  = '{OP_SRAI, 32'h8000_0000, 0, 32'h404, 0, 2'd0, 0, mk(32'hF800_0000, 32'hF800_0000, 1, 1, 1, 0, 0, 2'd0)};
        vt[7]  = '{OP_ADDW, 32'd1, 32'd1, 0, 0, 2'd0, 0, mk(0, 0, 0, 0, 1, 0, 0, 2'd1)};
        vt[8]  = '{OP_LUI,  0, 0, 32'h1234_5000, 0, 2'd0, 0, mk(32'h1234_5000, 32'h1234_5000, 1, 1, 1, 0, 0, 2'd0)};
        vt[9]  = '{OP_ADD,  32'd1, 32'h77, 0, 0, 2'd2, 32'h100, mk(32'h101, 32'h101, 1, 1, 1, 0, 0, 2'd0)};
        vt[10] = '{OP_ADD,  32'd7, 32'd0, 0, 0, 2'd3, 32'h100, mk(32'd7, 32'd7, 1, 1, 1, 0, 0, 2'd0)};
        // ready is held high so any stray memory request is seen by the monitor
        mem_req_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(vt[i].e);
            fwd_ext = vt[i].fext;
            issue(vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].imm, vt[i].pc, 2'd0, vt[i].f2);
            tick;
        end
        mem_req_ready = 1'b0;

        // reset while waiting for a load response, then a late response
        mr.we = 1'b0; mr.addr = 32'h3000;
        mem_q.push_back(mr);
        issue(OP_LW, 32'h3000, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0);
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h5555_5555;
        tick;
        mem_resp_valid = 1'b0;
        chk("abandon_out_valid", {31'd0, m_out_valid}, 32'd0);
        chk("abandon_in_ready", {31'd0, m_in_ready}, 32'd1);
        tick;
        chk("abandon_still_idle", {31'd0, m_out_valid}, 32'd0);
        chk("abandon_data", m_data, 32'd0);

        repeat (3) tick;
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("mem_q_drained", mem_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
